// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster defaults and pipeline types for the VGA output stage.
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FRONT_DEF  = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BACK_DEF   = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FRONT_DEF  = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BACK_DEF   = 33;
   localparam int COLOR_W_DEF  = 10;

   localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam int COORD_W  = 11;
   localparam int PIX_LAT  = 3;
   localparam int NUM_BARS = 8;

   // Sync and blank travel together down the delay line so they stay aligned with colour.
   typedef struct packed {
      logic hsN;
      logic vsN;
      logic active;
   } syncBits_t;

   localparam syncBits_t SYNC_IDLE = '{hsN: 1'b1, vsN: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_color_bar_gen.sv
// Combinational colour-bar pattern: eight vertical bars from white on the left to black on the right.
module vga_color_bar_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int COLOR_W  = COLOR_W_DEF
) (
   input  logic [COORD_W-1:0] x,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue
);

   logic [COORD_W-1:0] barIdx;
   logic [2:0]         k;

   // Bar index counts up left to right; k counts down so the leftmost bar is all ones.
   always_comb begin
      barIdx = x / COORD_W'(H_ACTIVE / NUM_BARS);
      k      = 3'd7 - barIdx[2:0];
      red    = {COLOR_W{k[2]}};
      green  = {COLOR_W{k[1]}};
      blue   = {COLOR_W{k[0]}};
   end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA raster generator and DAC pin driver with a fixed three-cycle pixel pipeline.
// Optional internal colour bars are enabled with `define VGA_PIXEL_OUT_TESTBARS_EN.
module vga_pixel_out
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FRONT  = H_FRONT_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BACK   = H_BACK_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FRONT  = V_FRONT_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BACK   = V_BACK_DEF,
   parameter int COLOR_W  = COLOR_W_DEF
) (
   input  logic               iCLK,
   input  logic               iRST_N,
`ifdef VGA_PIXEL_OUT_TESTBARS_EN
   input  logic               iTest_Sel,
`endif
   input  logic [COLOR_W-1:0] iRed,
   input  logic [COLOR_W-1:0] iGreen,
   input  logic [COLOR_W-1:0] iBlue,
   output logic               oRequest,
   output logic [COORD_W-1:0] oCurrent_X,
   output logic [COORD_W-1:0] oCurrent_Y,
   output logic               oFrame_Start,
   output logic [COLOR_W-1:0] oVGA_R,
   output logic [COLOR_W-1:0] oVGA_G,
   output logic [COLOR_W-1:0] oVGA_B,
   output logic               oVGA_HS,
   output logic               oVGA_VS,
   output logic               oVGA_BLANK_N
);

   localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_ACTIVE + H_FRONT;
   localparam int HS_END   = H_ACTIVE + H_FRONT + H_SYNC - 1;
   localparam int VS_START = V_ACTIVE + V_FRONT;
   localparam int VS_END   = V_ACTIVE + V_FRONT + V_SYNC - 1;

   logic               running;
   logic [COORD_W-1:0] hCnt;
   logic [COORD_W-1:0] vCnt;
   syncBits_t          sync0;
   syncBits_t          syncPipe [PIX_LAT];
   logic [COLOR_W-1:0] selRed;
   logic [COLOR_W-1:0] selGreen;
   logic [COLOR_W-1:0] selBlue;

   // The first edge after reset only arms the raster, so pixel (0,0) is requested on the second edge.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         running <= 1'b0;
         hCnt    <= '0;
         vCnt    <= '0;
      end else begin
         running <= 1'b1;
         if (running) begin
            if (hCnt == COORD_W'(H_TOTAL - 1)) begin
               hCnt <= '0;
               vCnt <= (vCnt == COORD_W'(V_TOTAL - 1)) ? '0 : vCnt + 1'b1;
            end else begin
               hCnt <= hCnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      sync0        = SYNC_IDLE;
      sync0.active = running && (hCnt < COORD_W'(H_ACTIVE)) && (vCnt < COORD_W'(V_ACTIVE));
      sync0.hsN    = !((hCnt >= COORD_W'(HS_START)) && (hCnt <= COORD_W'(HS_END)));
      sync0.vsN    = !((vCnt >= COORD_W'(VS_START)) && (vCnt <= COORD_W'(VS_END)));
   end

   // Stage 1 issues the request; syncPipe carries sync/blank down to the pins in step with it.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < PIX_LAT; i++) syncPipe[i] <= SYNC_IDLE;
         oCurrent_X   <= '0;
         oCurrent_Y   <= '0;
         oFrame_Start <= 1'b0;
      end else begin
         syncPipe[0] <= sync0;
         for (int i = 1; i < PIX_LAT; i++) syncPipe[i] <= syncPipe[i-1];
         oCurrent_X   <= sync0.active ? hCnt : '0;
         oCurrent_Y   <= sync0.active ? vCnt : '0;
         oFrame_Start <= sync0.active && (hCnt == '0) && (vCnt == '0);
      end
   end

   assign oRequest = syncPipe[0].active;

`ifdef VGA_PIXEL_OUT_TESTBARS_EN
   logic [COORD_W-1:0] x2;
   logic [COLOR_W-1:0] barRed;
   logic [COLOR_W-1:0] barGreen;
   logic [COLOR_W-1:0] barBlue;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) x2 <= '0;
      else         x2 <= oCurrent_X;
   end

   vga_color_bar_gen #(.H_ACTIVE(H_ACTIVE), .COLOR_W(COLOR_W)) barGen (
      .x    (x2),
      .red  (barRed),
      .green(barGreen),
      .blue (barBlue)
   );

   always_comb begin
      selRed   = iTest_Sel ? barRed   : iRed;
      selGreen = iTest_Sel ? barGreen : iGreen;
      selBlue  = iTest_Sel ? barBlue  : iBlue;
   end
`else
   always_comb begin
      selRed   = iRed;
      selGreen = iGreen;
      selBlue  = iBlue;
   end
`endif

   // Colour is gated by the delayed active flag so blanking-time garbage never reaches the DAC.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oVGA_R <= '0;
         oVGA_G <= '0;
         oVGA_B <= '0;
      end else begin
         oVGA_R <= syncPipe[PIX_LAT-2].active ? selRed   : '0;
         oVGA_G <= syncPipe[PIX_LAT-2].active ? selGreen : '0;
         oVGA_B <= syncPipe[PIX_LAT-2].active ? selBlue  : '0;
      end
   end

   assign oVGA_HS      = syncPipe[PIX_LAT-1].hsN;
   assign oVGA_VS      = syncPipe[PIX_LAT-1].vsN;
   assign oVGA_BLANK_N = syncPipe[PIX_LAT-1].active;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Self-checking bench for vga_pixel_out against a raster model indexed by pixel-clock count.
module tb_vga_pixel_out;

   localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
   localparam int VA = 24,  VF = 3,  VSW = 2,  VB = 4;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rstN;
   logic        testSel;
   logic [9:0]  iRed, iGreen, iBlue;
   logic        oRequest, oFrame_Start, oVGA_HS, oVGA_VS, oVGA_BLANK_N;
   logic [10:0] oCurrent_X, oCurrent_Y;
   logic [9:0]  oVGA_R, oVGA_G, oVGA_B;

   int assertCount = 0;
   int failCount   = 0;
   int n;
   logic [9:0] blueTab [256];

   bit pendValid;
   int pendX, pendY;

   int lastHsFall, lastHsRise, lastBlankRise, lastVsFall, lastFs, fsCount, maxX, maxY;
   bit prevHs, prevVs, prevBlank;

   always #20 clk = ~clk;

   vga_pixel_out #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB), .COLOR_W(10)
   ) dut (
      .iCLK        (clk),
      .iRST_N      (rstN),
`ifdef VGA_PIXEL_OUT_TESTBARS_EN
      .iTest_Sel   (testSel),
`endif
      .iRed        (iRed),
      .iGreen      (iGreen),
      .iBlue       (iBlue),
      .oRequest    (oRequest),
      .oCurrent_X  (oCurrent_X),
      .oCurrent_Y  (oCurrent_Y),
      .oFrame_Start(oFrame_Start),
      .oVGA_R      (oVGA_R),
      .oVGA_G      (oVGA_G),
      .oVGA_B      (oVGA_B),
      .oVGA_HS     (oVGA_HS),
      .oVGA_VS     (oVGA_VS),
      .oVGA_BLANK_N(oVGA_BLANK_N)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, n, observed, expected);
      end
   endtask

   function automatic int hOf(input int p);
      return p % HT;
   endfunction

   function automatic int vOf(input int p);
      return (p / HT) % VT;
   endfunction

   function automatic bit isActive(input int p);
      return (p >= 0) && (hOf(p) < HA) && (vOf(p) < VA);
   endfunction

   task automatic clearTracking();
      n = 0;
      lastHsFall = -1; lastHsRise = -1; lastBlankRise = -1; lastVsFall = -1; lastFs = -1;
      fsCount = 0; maxX = 0; maxY = 0;
      prevHs = 1'b1; prevVs = 1'b1; prevBlank = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".req"},   int'(oRequest),     0);
      checkOutput({tag, ".x"},     int'(oCurrent_X),   0);
      checkOutput({tag, ".y"},     int'(oCurrent_Y),   0);
      checkOutput({tag, ".fs"},    int'(oFrame_Start), 0);
      checkOutput({tag, ".r"},     int'(oVGA_R),       0);
      checkOutput({tag, ".g"},     int'(oVGA_G),       0);
      checkOutput({tag, ".b"},     int'(oVGA_B),       0);
      checkOutput({tag, ".hs"},    int'(oVGA_HS),      1);
      checkOutput({tag, ".vs"},    int'(oVGA_VS),      1);
      checkOutput({tag, ".blank"}, int'(oVGA_BLANK_N), 0);
   endtask

   // Expected pins after the n-th edge since reset release: request shows pixel n-2, DAC shows pixel n-4.
   task automatic checkCycle();
      int p1, p3, h, v, k;
      int eR, eG, eB, eHs, eVs, eBl;
      bit eReq;
      p1   = n - 2;
      eReq = isActive(p1);
      checkOutput("request", int'(oRequest), int'(eReq));
      checkOutput("currentX", int'(oCurrent_X), eReq ? hOf(p1) : 0);
      checkOutput("currentY", int'(oCurrent_Y), eReq ? vOf(p1) : 0);
      checkOutput("frameStart", int'(oFrame_Start), int'(eReq && hOf(p1) == 0 && vOf(p1) == 0));

      p3 = n - 4;
      eR = 0; eG = 0; eB = 0; eHs = 1; eVs = 1; eBl = 0;
      if (p3 >= 0) begin
         h   = hOf(p3);
         v   = vOf(p3);
         eHs = (h >= HA + HF && h < HA + HF + HSW) ? 0 : 1;
         eVs = (v >= VA + VF && v < VA + VF + VSW) ? 0 : 1;
         eBl = int'(isActive(p3));
         if (isActive(p3)) begin
            if (testSel) begin
               k  = 7 - h / (HA / 8);
               eR = ((k >> 2) & 1) ? 1023 : 0;
               eG = ((k >> 1) & 1) ? 1023 : 0;
               eB = (k & 1) ? 1023 : 0;
            end else begin
               eR = h;
               eG = v;
               eB = int'(blueTab[(h + 7 * v) % 256]);
            end
         end
      end
      checkOutput("vgaR", int'(oVGA_R), eR);
      checkOutput("vgaG", int'(oVGA_G), eG);
      checkOutput("vgaB", int'(oVGA_B), eB);
      checkOutput("vgaHS", int'(oVGA_HS), eHs);
      checkOutput("vgaVS", int'(oVGA_VS), eVs);
      checkOutput("blankN", int'(oVGA_BLANK_N), eBl);

      if (prevHs && !oVGA_HS) begin
         if (lastHsFall >= 0) checkOutput("hsPeriod", n - lastHsFall, HT);
         if (lastBlankRise >= 0 && n - lastBlankRise < HT)
            checkOutput("hsAfterBlank", n - lastBlankRise, HA + HF);
         lastHsFall = n;
      end
      if (!prevHs && oVGA_HS && lastHsFall >= 0) checkOutput("hsWidth", n - lastHsFall, HSW);
      if (!prevBlank && oVGA_BLANK_N) lastBlankRise = n;
      if (prevBlank && !oVGA_BLANK_N && lastBlankRise >= 0) checkOutput("blankWidth", n - lastBlankRise, HA);
      if (prevVs && !oVGA_VS) begin
         if (lastVsFall >= 0) checkOutput("vsPeriod", n - lastVsFall, FRAME);
         lastVsFall = n;
      end
      if (!prevVs && oVGA_VS && lastVsFall >= 0) checkOutput("vsWidth", n - lastVsFall, VSW * HT);
      if (oFrame_Start) begin
         if (lastFs >= 0) checkOutput("frameStartPeriod", n - lastFs, FRAME);
         lastFs = n;
         fsCount++;
      end
      if (oRequest) begin
         if (int'(oCurrent_X) > maxX) maxX = int'(oCurrent_X);
         if (int'(oCurrent_Y) > maxY) maxY = int'(oCurrent_Y);
      end
      prevHs = oVGA_HS; prevVs = oVGA_VS; prevBlank = oVGA_BLANK_N;
   endtask

   // One pixel clock: check the pins, then play the upstream filter with its one-cycle read latency.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      if (rstN) begin
         n++;
         checkCycle();
      end else begin
         checkResetValues("inReset");
      end
      if (pendValid) begin
         iRed   = 10'(pendX);
         iGreen = 10'(pendY);
         iBlue  = blueTab[(pendX + 7 * pendY) % 256];
      end else begin
         iRed   = 10'($urandom);
         iGreen = 10'($urandom);
         iBlue  = 10'($urandom);
      end
      pendValid = oRequest;
      pendX     = int'(oCurrent_X);
      pendY     = int'(oCurrent_Y);
   endtask

   task automatic runCycles(input int count);
      for (int i = 0; i < count; i++) applyStimulus();
   endtask

   initial begin
      bit found;
      int runLen;
      rstN = 1'b0;
      testSel = 1'b0;
      iRed = '0; iGreen = '0; iBlue = '0;
      pendValid = 1'b0; pendX = 0; pendY = 0;
      for (int i = 0; i < 256; i++) blueTab[i] = 10'($urandom);
      clearTracking();

      runCycles(3);
      @(negedge clk);
      rstN = 1'b1;
      clearTracking();
      $display("[TB] reset released, free-running two frames");
      runLen = 2 * FRAME + 200;
      runCycles(runLen);
      checkOutput("maxX", maxX, HA - 1);
      checkOutput("maxY", maxY, VA - 1);
      checkOutput("frameStartCount", fsCount, (runLen - 2) / FRAME + 1);

      found = 1'b0;
      for (int i = 0; i < FRAME + 2 && !found; i++) begin
         if ((n - 1) % FRAME == 20 * HT + 300) found = 1'b1;
         else applyStimulus();
      end
      checkOutput("seekMidFrame", int'(found), 1);

      #2;
      rstN = 1'b0;
      #1;
      checkResetValues("asyncReset");
`ifdef VGA_PIXEL_OUT_TESTBARS_EN
      testSel = 1'b1;
`endif
      runCycles(5);
      @(negedge clk);
      rstN = 1'b1;
      clearTracking();
      $display("[TB] restarted after mid-frame reset");
      runCycles(3 * HT + 50);
      checkOutput("restartFrameStart", fsCount, 1);
      checkOutput("restartMaxX", maxX, HA - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
